// File: rtl/mips16_pkg.sv
// Shared MIPS16 datapath constants: data width, operand-select encodings, selector default.
package mips16_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        SEL_RF    = 2'd0,
        SEL_EXMEM = 2'd1,
        SEL_MEMWB = 2'd2,
        SEL_IMM   = 2'd3
    } fwd_sel_e;

    localparam logic [DATA_W-1:0] DEFAULT_DATA = 16'h0000;

    // State bits double as flags: bit0 = main valid, bit1 = skid valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } buf_state_e;

endpackage

// File: rtl/pipe_sel_mux_sel_core.sv
// Combinational NUM_IN-way selector; out-of-range selects yield DEFAULT_VAL and raise err.
module pipe_sel_mux_sel_core #(
    parameter int unsigned   WIDTH       = 16,
    parameter int unsigned   NUM_IN      = 4,
    parameter int unsigned   SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        data_c,
    output logic                    err_c
);

    always_comb begin
        data_c = DEFAULT_VAL;
        err_c  = 1'b1;
        for (int k = 0; k < int'(NUM_IN); k++) begin
            if (sel == SEL_W'(k)) begin
                data_c = in_data[k*WIDTH +: WIDTH];
                err_c  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_sel_mux.sv
// Registered N-way selector behind a valid/ready handshake with a 2-entry skid buffer.
module pipe_sel_mux
    import mips16_pkg::*;
#(
    parameter int unsigned      WIDTH       = mips16_pkg::DATA_W,
    parameter int unsigned      NUM_IN      = 4,
    parameter int unsigned      SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = WIDTH'(mips16_pkg::DEFAULT_DATA)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_sel_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    buf_state_e       state, state_d;
    logic [WIDTH-1:0] skid_data;
    logic             skid_err;
    logic [WIDTH-1:0] sel_data_c;
    logic             sel_err_c;
    logic             acc_c, con_c;
    logic             ld_main_in_c, ld_main_skid_c, ld_skid_c;

    pipe_sel_mux_sel_core #(
        .WIDTH      (WIDTH),
        .NUM_IN     (NUM_IN),
        .SEL_W      (SEL_W),
        .DEFAULT_VAL(DEFAULT_VAL)
    ) u_sel_core (
        .in_data(in_data),
        .sel    (sel),
        .data_c (sel_data_c),
        .err_c  (sel_err_c)
    );

    // Handshake flags come straight from state flops, so in_ready never depends on out_ready.
    assign out_valid = state[0];
    assign in_ready  = ~state[1];
    assign acc_c     = in_valid && in_ready;
    assign con_c     = out_valid && out_ready;

    always_comb begin
        state_d        = state;
        ld_main_in_c   = 1'b0;
        ld_main_skid_c = 1'b0;
        ld_skid_c      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (acc_c) begin
                        ld_main_in_c = 1'b1;
                        state_d      = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc_c && con_c) begin
                        ld_main_in_c = 1'b1;
                    end else if (acc_c) begin
                        ld_skid_c = 1'b1;
                        state_d   = ST_FULL;
                    end else if (con_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (con_c) begin
                        ld_main_skid_c = 1'b1;
                        state_d        = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_EMPTY;
            out_data    <= '0;
            out_sel_err <= 1'b0;
            skid_data   <= '0;
            skid_err    <= 1'b0;
        end else begin
            state <= state_d;
            if (ld_main_in_c) begin
                out_data    <= sel_data_c;
                out_sel_err <= sel_err_c;
            end else if (ld_main_skid_c) begin
                out_data    <= skid_data;
                out_sel_err <= skid_err;
            end
            if (ld_skid_c) begin
                skid_data <= sel_data_c;
                skid_err  <= sel_err_c;
            end
        end
    end

endmodule

// File: doc/pipe_sel_mux.md
Name: pipe_sel_mux

Overview:
- Parametrised, registered N-way data selector; the next generation of the fixed 16-bit 2/3/4-input muxes in the datapath.
- Selects one of NUM_IN WIDTH-bit operands and drives the result from a registered output stage.
- Uses a valid/ready handshake with a 2-entry skid buffer, so it can sit between pipeline stages (e.g. ID→EX operand/forwarding select) and sustain full throughput under downstream stalls.
- Out-of-range selects produce a parametrised default value and raise a flag. Pipeline flush is supported.

Parameters:
- WIDTH, 16, data width of each input and of the output.
- NUM_IN, 4, number of selectable inputs (≥2).
- SEL_W, 2, select width; must satisfy 2^SEL_W ≥ NUM_IN.
- DEFAULT_VAL, 0, value output when sel ≥ NUM_IN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  flattened operands; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  select, sampled with in_data on accept.
- in_valid  input  1  upstream has a transfer.
- in_ready  output  1  block can accept; a transfer occurs when in_valid && in_ready.
- flush  input  1  synchronous discard of all buffered entries.
- out_data  output  WIDTH  registered selected value.
- out_sel_err  output  1  registered; 1 if the entry at the output was accepted with sel ≥ NUM_IN.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_data=0, out_sel_err=0.
  - skid entry invalid and its data cleared; in_ready=1.
  - Takes effect immediately and regardless of clk; any buffered data is lost.
- Selection is combinational from in_data/sel at the accepting edge:
  - sel < NUM_IN → input[sel], err=0.
  - sel ≥ NUM_IN → DEFAULT_VAL, err=1.
  - Selected data and err travel together through both buffer entries.
- Storage: main entry (drives out_*) plus a skid entry.
- in_ready = NOT skid_valid. It is registered-derived only and has no combinational path from out_ready.
- Latency: an accepted transfer appears on out_data exactly 1 cycle later when main is empty or being consumed that cycle.
- Per-edge actions, with acc = in_valid&&in_ready and con = out_valid&&out_ready:
  - State EMPTY (main invalid, skid invalid):
    - acc → load main, go to ONE.
  - State ONE (main valid, skid invalid):
    - acc&con → load main with new data, stay ONE.
    - acc only → load skid, go to FULL.
    - con only → go to EMPTY.
    - neither → hold.
  - State FULL (both valid; in_ready=0):
    - con → move skid to main, go to ONE.
    - otherwise hold.
  - Ordering is never violated.
- Stall: while out_valid=1 and out_ready=0, out_data/out_sel_err are held stable.
- Flush:
  - At the edge where flush=1, main and skid become invalid (go to EMPTY); in_ready=1 next cycle.
  - Flush overrides a simultaneous accept (input dropped) and a simultaneous consume (the consume still counts downstream, but nothing is retained).
  - out_data is not cleared by flush; only out_valid drops.
- Full throughput: with out_ready held 1, one transfer per cycle and the skid never fills.

Decomposition:
- Shared package mips16_pkg holds:
  - DATA_W=16.
  - Select encodings for datapath users (SEL_RF=0, SEL_EXMEM=1, SEL_MEMWB=2, SEL_IMM=3).
  - Default-value constant.
- One sub-module is natural: sel_core, the purely combinational NUM_IN-way selector producing data and err.
- The skid/handshake logic lives in pipe_sel_mux.

Test Plan:
- Reset and idle: assert rst mid-cycle with FULL state → out_valid=0, out_data=0, out_sel_err=0, in_ready=1 immediately, without waiting for clk.
- Basic select and latency: WIDTH=16, NUM_IN=4, inputs {0x1111,0x2222,0x3333,0x4444}, sel=2, in_valid=1, out_ready=1 → next cycle out_valid=1, out_data=0x3333, out_sel_err=0.
- Out-of-range: NUM_IN=3, SEL_W=2, DEFAULT_VAL=0xDEAD, sel=3 → out_data=0xDEAD, out_sel_err=1.
- Backpressure: stream A=0x000A, B=0x000B, C=0x000C with out_ready=0 → after A and B are accepted, in_ready=0 and C is held. Then raise out_ready → outputs A, B, C in order, with no loss or duplication.
- Full throughput: out_ready=1, 8 back-to-back transfers → 8 outputs on 8 consecutive cycles; in_ready stays 1.
- Flush collision: state FULL, assert flush together with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed input never appears at the output.
